// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage in-order pipeline.
// Define PIPE_HAZARD_PERF_EN to add the stall/flush/multi-cycle performance counters.
module pipe_hazard_ctrl #(
    parameter int RF_AW      = 5,
    parameter int MC_MAX_CYC = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RF_AW-1:0] id_rs1_idx,
    input  logic [RF_AW-1:0] id_rs2_idx,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [RF_AW-1:0] ex_rs1_idx,
    input  logic [RF_AW-1:0] ex_rs2_idx,
    input  logic [RF_AW-1:0] ex_rd_idx,
    input  logic             ex_reg_we,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic [RF_AW-1:0] mem_rd_idx,
    input  logic             mem_reg_we,
    input  logic [RF_AW-1:0] wb_rd_idx,
    input  logic             wb_reg_we,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mc_timeout,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mc_cyc_cnt,
`endif
    output logic [1:0]       state_o
);

    localparam int MC_CW = (MC_MAX_CYC > 1) ? $clog2(MC_MAX_CYC) : 1;
    localparam logic [MC_CW-1:0] MC_LAST = MC_CW'(MC_MAX_CYC - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_BUSY = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [MC_CW-1:0] mc_cnt;
    logic             load_use;
    logic             stall_evt;
    logic             flush_evt;

    assign load_use = ex_is_load && ex_reg_we && (ex_rd_idx != '0) &&
                      ((id_uses_rs1 && (id_rs1_idx == ex_rd_idx)) ||
                       (id_uses_rs2 && (id_rs2_idx == ex_rd_idx)));

    assign stall_evt = (state == RUN) && !ex_branch_taken && !ex_mc_start && load_use;
    assign flush_evt = (state == RUN) && ex_branch_taken;
    assign state_o   = state;

    // Enables mean "advance normally"; flush/bubble independently force a NOP load.
    always_comb begin
        next_state    = state;
        pc_en         = 1'b0;
        pc_redirect   = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_timeout    = 1'b0;
        if (rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_redirect  = 1'b1;
                        pc_en        = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        next_state   = FLUSH;
                    end else if (ex_mc_start) begin
                        next_state = MC_BUSY;
                    end else if (load_use) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        id_ex_en = 1'b1;
                    end
                end
                MC_BUSY: begin
                    ex_mem_bubble = 1'b1;
                    if (ex_mc_done) begin
                        ex_mem_bubble = 1'b0;
                        next_state    = RUN;
                    end else if (mc_cnt == MC_LAST) begin
                        mc_timeout = 1'b1;
                        next_state = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    pc_en       = 1'b1;
                    id_ex_en    = 1'b1;
                    next_state  = RUN;
                end
                default: next_state = RUN;
            endcase
        end
    end

    // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (rst) begin
            if (mem_reg_we && (mem_rd_idx != '0) && (mem_rd_idx == ex_rs1_idx))
                fwd_a_sel = 2'b01;
            else if (wb_reg_we && (wb_rd_idx != '0) && (wb_rd_idx == ex_rs1_idx))
                fwd_a_sel = 2'b10;
            if (mem_reg_we && (mem_rd_idx != '0) && (mem_rd_idx == ex_rs2_idx))
                fwd_b_sel = 2'b01;
            else if (wb_reg_we && (wb_rd_idx != '0) && (wb_rd_idx == ex_rs2_idx))
                fwd_b_sel = 2'b10;
        end
    end

    // The watchdog count restarts every time MC_BUSY is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == MC_BUSY)
                mc_cnt <= mc_cnt + MC_CW'(1);
            else
                mc_cnt <= '0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            mc_cyc_cnt <= '0;
        end else begin
            if (stall_evt)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (state == MC_BUSY)
                mc_cyc_cnt <= mc_cyc_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven RUN vectors plus hand-written
// branch, multi-cycle, watchdog and async-reset sequences, scored through an expectation queue.
module tb_pipe_hazard_ctrl;

    localparam int RF_AW      = 5;
    localparam int MC_MAX_CYC = 32;
    localparam int CNT_W      = 32;

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_BUSY  = 2'b01;
    localparam logic [1:0] S_FLUSH = 2'b10;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       uses1;
        logic       uses2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_load;
        logic       br;
        logic       mc_start;
        logic       mc_done;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
    } stim_t;

    typedef struct packed {
        logic       pc_en;
        logic       pc_redirect;
        logic       if_id_en;
        logic       if_id_flush;
        logic       id_ex_en;
        logic       id_ex_bubble;
        logic       ex_mem_bubble;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       mc_timeout;
        logic [1:0] state;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
        string name;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [RF_AW-1:0] id_rs1_idx, id_rs2_idx, ex_rs1_idx, ex_rs2_idx, ex_rd_idx;
    logic [RF_AW-1:0] mem_rd_idx, wb_rd_idx;
    logic             id_uses_rs1, id_uses_rs2, ex_reg_we, ex_is_load;
    logic             ex_branch_taken, ex_mc_start, ex_mc_done, mem_reg_we, wb_reg_we;
    logic             pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en;
    logic             id_ex_bubble, ex_mem_bubble, mc_timeout;
    logic [1:0]       fwd_a_sel, fwd_b_sel, state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, mc_cyc_cnt;
`endif

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    pipe_hazard_ctrl #(
        .RF_AW      (RF_AW),
        .MC_MAX_CYC (MC_MAX_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_idx      (id_rs1_idx),
        .id_rs2_idx      (id_rs2_idx),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rs1_idx      (ex_rs1_idx),
        .ex_rs2_idx      (ex_rs2_idx),
        .ex_rd_idx       (ex_rd_idx),
        .ex_reg_we       (ex_reg_we),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .ex_mc_done      (ex_mc_done),
        .mem_rd_idx      (mem_rd_idx),
        .mem_reg_we      (mem_reg_we),
        .wb_rd_idx       (wb_rd_idx),
        .wb_reg_we       (wb_reg_we),
        .pc_en           (pc_en),
        .pc_redirect     (pc_redirect),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mc_timeout      (mc_timeout),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mc_cyc_cnt      (mc_cyc_cnt),
`endif
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic pe, input logic rd, input logic ie, input logic ifl,
                                input logic ee, input logic eb, input logic mb,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic to, input logic [1:0] st);
        exp_t e;
        e = '{pe, rd, ie, ifl, ee, eb, mb, fa, fb, to, st};
        return e;
    endfunction

    function automatic exp_t e_run(input logic [1:0] fa, input logic [1:0] fb);
        return mk(1, 0, 1, 0, 1, 0, 0, fa, fb, 0, S_RUN);
    endfunction

    function automatic exp_t e_stall(input logic [1:0] fa, input logic [1:0] fb);
        return mk(0, 0, 0, 0, 0, 1, 0, fa, fb, 0, S_RUN);
    endfunction

    function automatic exp_t e_busy(input logic [1:0] fa, input logic [1:0] fb);
        return mk(0, 0, 0, 0, 0, 0, 1, fa, fb, 0, S_BUSY);
    endfunction

    task automatic drive(input stim_t s);
        id_rs1_idx      = s.id_rs1;
        id_rs2_idx      = s.id_rs2;
        id_uses_rs1     = s.uses1;
        id_uses_rs2     = s.uses2;
        ex_rs1_idx      = s.ex_rs1;
        ex_rs2_idx      = s.ex_rs2;
        ex_rd_idx       = s.ex_rd;
        ex_reg_we       = s.ex_we;
        ex_is_load      = s.ex_load;
        ex_branch_taken = s.br;
        ex_mc_start     = s.mc_start;
        ex_mc_done      = s.mc_done;
        mem_rd_idx      = s.mem_rd;
        mem_reg_we      = s.mem_we;
        wb_rd_idx       = s.wb_rd;
        wb_reg_we       = s.wb_we;
    endtask

    task automatic apply_stimulus(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        drive(s);
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name);
        exp_t e;
        exp_t act;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, nothing expected", name);
            return;
        end
        e   = exp_q.pop_front();
        act = '{pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                ex_mem_bubble, fwd_a_sel, fwd_b_sel, mc_timeout, state_o};
        if (act !== e) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b required %b (pc_en,redir,ifid_en,ifid_fl,idex_en,idex_bub,exmem_bub,fa,fb,to,st)",
                     name, act, e);
        end
    endtask

    task automatic step(input stim_t s, input exp_t e, input string name);
        apply_stimulus(s, e);
        @(negedge clk);
        check_output(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t  vecs[13];
        stim_t s;
        stim_t z;
        exp_t  e_zero;

        n_checks = 0;
        n_fail   = 0;
        z        = '0;
        e_zero   = '0;

        s = z; vecs[0] = '{s, e_run(2'b00, 2'b00), "idle"};
        s = z; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 5; s.id_rs1 = 5; s.uses1 = 1;
        vecs[1] = '{s, e_stall(2'b00, 2'b00), "load_use_rs1"};
        s = z; s.ex_we = 1; s.ex_rd = 5; s.id_rs1 = 5; s.uses1 = 1;
        vecs[2] = '{s, e_run(2'b00, 2'b00), "load_use_cleared"};
        s = z; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 0; s.id_rs1 = 0; s.uses1 = 1;
        vecs[3] = '{s, e_run(2'b00, 2'b00), "load_use_rd0"};
        s = z; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 7; s.id_rs2 = 7; s.uses2 = 1;
        vecs[4] = '{s, e_stall(2'b00, 2'b00), "load_use_rs2"};
        s = z; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 7; s.id_rs2 = 7; s.uses2 = 0;
        vecs[5] = '{s, e_run(2'b00, 2'b00), "load_use_not_read"};
        s = z; s.ex_load = 1; s.ex_we = 0; s.ex_rd = 7; s.id_rs2 = 7; s.uses2 = 1;
        vecs[6] = '{s, e_run(2'b00, 2'b00), "load_use_no_we"};
        s = z; s.mem_rd = 3; s.wb_rd = 3; s.ex_rs1 = 3; s.mem_we = 1; s.wb_we = 1; s.ex_rs2 = 9;
        vecs[7] = '{s, e_run(2'b01, 2'b00), "fwd_mem_beats_wb"};
        s = z; s.mem_rd = 3; s.wb_rd = 3; s.ex_rs1 = 3; s.mem_we = 0; s.wb_we = 1; s.ex_rs2 = 9;
        vecs[8] = '{s, e_run(2'b10, 2'b00), "fwd_wb"};
        s = z; s.mem_rd = 0; s.wb_rd = 0; s.ex_rs1 = 0; s.ex_rs2 = 0; s.mem_we = 1; s.wb_we = 1;
        vecs[9] = '{s, e_run(2'b00, 2'b00), "fwd_idx_zero"};
        s = z; s.ex_rs1 = 6; s.ex_rs2 = 4; s.mem_rd = 4; s.mem_we = 1; s.wb_rd = 6; s.wb_we = 1;
        vecs[10] = '{s, e_run(2'b10, 2'b01), "fwd_a_wb_b_mem"};
        s = z; s.ex_rs1 = 8; s.ex_rs2 = 8; s.wb_rd = 8; s.wb_we = 1; s.mem_rd = 2; s.mem_we = 1;
        vecs[11] = '{s, e_run(2'b10, 2'b10), "fwd_both_wb"};
        s = z; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 5; s.id_rs1 = 5; s.uses1 = 1;
        s.ex_rs2 = 1; s.mem_rd = 1; s.mem_we = 1;
        vecs[12] = '{s, e_stall(2'b00, 2'b01), "fwd_during_stall"};

        // Reset held with mc_start and a forwarding match: everything must stay quiet.
        rst = 1'b0;
        drive(z);
        s = z; s.mc_start = 1; s.mem_rd = 3; s.mem_we = 1; s.ex_rs1 = 3;
        for (int i = 0; i < 3; i++)
            step(s, e_zero, "reset_hold");
        drive(z);
        rst = 1'b1;
        step(z, e_run(2'b00, 2'b00), "reset_release");

        for (int i = 0; i < 13; i++)
            step(vecs[i].s, vecs[i].e, vecs[i].name);

        // Branch beats load-use; a second branch seen during FLUSH is ignored.
        s = z; s.br = 1; s.ex_load = 1; s.ex_we = 1; s.ex_rd = 5; s.id_rs1 = 5; s.uses1 = 1;
        step(s, mk(1, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, S_RUN), "branch_over_load_use");
        s = z; s.br = 1;
        step(s, mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, S_FLUSH), "flush_ignores_branch");
        step(z, e_run(2'b00, 2'b00), "after_flush");

        // Branch beats mc_start.
        s = z; s.br = 1; s.mc_start = 1;
        step(s, mk(1, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, S_RUN), "branch_over_mc_start");
        step(z, mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, S_FLUSH), "flush_cycle");
        step(z, e_run(2'b00, 2'b00), "after_flush_2");

        // Multi-cycle op completing after 7 frozen cycles.
        s = z; s.mc_start = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_RUN), "mc_start");
        for (int i = 1; i <= 7; i++) begin
            s = z;
            if (i == 2) s.br = 1;
            if (i == 4) begin s.mem_rd = 3; s.mem_we = 1; s.ex_rs1 = 3; end
            step(s, e_busy((i == 4) ? 2'b01 : 2'b00, 2'b00), "mc_busy");
        end
        s = z; s.mc_done = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_BUSY), "mc_done");
        step(z, e_run(2'b00, 2'b00), "after_mc_done");

        // Never done: watchdog fires on the 32nd busy cycle, exactly once.
        s = z; s.mc_start = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_RUN), "mc_start_to");
        for (int i = 1; i <= MC_MAX_CYC; i++)
            step(z, (i == MC_MAX_CYC) ? mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, S_BUSY)
                                      : e_busy(2'b00, 2'b00), "mc_watchdog");
        step(z, e_run(2'b00, 2'b00), "after_timeout");
        step(z, e_run(2'b00, 2'b00), "no_second_timeout");

        // done on the watchdog cycle wins; no pulse.
        s = z; s.mc_start = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_RUN), "mc_start_tie");
        for (int i = 1; i < MC_MAX_CYC; i++)
            step(z, e_busy(2'b00, 2'b00), "mc_busy_tie");
        s = z; s.mc_done = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_BUSY), "done_beats_timeout");
        step(z, e_run(2'b00, 2'b00), "after_tie");

        // Async reset in MC_BUSY takes effect before the next clock edge.
        s = z; s.mc_start = 1;
        step(s, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, S_RUN), "mc_start_rst");
        for (int i = 1; i <= 3; i++)
            step(z, e_busy(2'b00, 2'b00), "mc_busy_rst");
        #1;
        rst = 1'b0;
        #1;
        exp_q.push_back(e_zero);
        check_output("async_reset_mc");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step(z, e_run(2'b00, 2'b00), "after_async_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
